// File: rtl/seq_match_scheduler.sv
// Round-robin scheduler that feeds one channel's word at a time, MSB first,
// through a shared overlapping 4-bit sequence detector and reports the match count.
module seq_match_scheduler #(
  parameter int         NREQ    = 4,
  parameter int         WIDTH   = 8,
  parameter logic [3:0] PATTERN = 4'b1011,
  parameter int         IDW     = $clog2(NREQ),
  parameter int         CW      = $clog2(WIDTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] data,
  output logic [NREQ-1:0]       gnt,
  output logic                  busy,
  output logic                  ser_bit,
  output logic                  match_pulse,
  output logic                  done,
  output logic [IDW-1:0]        done_id,
  output logic [CW-1:0]         match_cnt
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] words [NREQ];
  logic [WIDTH-1:0] sreg;
  logic [2:0]       hist;
  logic [CW-1:0]    bit_cnt;
  logic [CW-1:0]    run_cnt;
  logic [IDW-1:0]   last;
  logic [IDW-1:0]   winner;
  logic [IDW-1:0]   cand;
  logic             found;
  logic             hit;
  logic             last_bit;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_words
    assign words[gi] = data[gi*WIDTH +: WIDTH];
  end

  // Search upward from the channel after the last grant, wrapping at NREQ-1.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = last;
    for (int k = 0; k < NREQ; k++) begin
      cand = (cand == IDW'(NREQ - 1)) ? '0 : cand + 1'b1;
      if (!found && req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  assign ser_bit  = (state == SHIFT) & sreg[WIDTH-1];
  assign busy     = (state != IDLE);
  assign last_bit = (bit_cnt == CW'(WIDTH - 1));
  // The bit-index guard keeps the cleared window from forming a false early match.
  assign hit      = (state == SHIFT) && ({hist, sreg[WIDTH-1]} == PATTERN) &&
                    (bit_cnt >= CW'(3));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (found) state_next = SHIFT;
      SHIFT:   if (last_bit) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt         <= '0;
      match_pulse <= 1'b0;
      done        <= 1'b0;
      done_id     <= '0;
      match_cnt   <= '0;
      sreg        <= '0;
      hist        <= '0;
      bit_cnt     <= '0;
      run_cnt     <= '0;
      last        <= IDW'(NREQ - 1);
    end else begin
      gnt         <= '0;
      match_pulse <= 1'b0;
      done        <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            sreg    <= words[winner];
            hist    <= '0;
            bit_cnt <= '0;
            run_cnt <= '0;
            last    <= winner;
            gnt     <= NREQ'(1) << winner;
          end
        end
        SHIFT: begin
          sreg    <= {sreg[WIDTH-2:0], 1'b0};
          hist    <= {hist[1:0], sreg[WIDTH-1]};
          bit_cnt <= bit_cnt + 1'b1;
          if (hit) begin
            match_pulse <= 1'b1;
            run_cnt     <= run_cnt + 1'b1;
          end
          // last holds the channel in flight until the next grant.
          if (last_bit) begin
            done      <= 1'b1;
            done_id   <= last;
            match_cnt <= run_cnt + {{(CW-1){1'b0}}, hit};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_match_scheduler.sv
// Bench for seq_match_scheduler: transaction-timeline model checked every cycle,
// plus directed scenarios with hand-computed grants, ids and counts.
module tb_seq_match_scheduler;
  localparam int         NREQ = 4;
  localparam int         W    = 8;
  localparam int         IDW  = 2;
  localparam int         CW   = 4;
  localparam logic [3:0] PAT  = 4'b1011;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [NREQ-1:0]     req = '0;
  logic [NREQ*W-1:0]   data = '0;
  logic [NREQ-1:0]     gnt;
  logic                busy, ser_bit, match_pulse, done;
  logic [IDW-1:0]      done_id;
  logic [CW-1:0]       match_cnt;

  int errors = 0;
  int checks = 0;

  // Model state: the one word in flight and when it was granted.
  int         cyc = 0;
  bit         m_active = 1'b0;
  int         m_t0 = 0;
  logic [W-1:0] m_word = '0;
  int         m_id = 0;
  int         m_last = NREQ - 1;
  int         m_done_id = 0;
  int         m_done_cnt = 0;

  int gq[$];
  int gcyc[$];
  int dq[$];
  int done_total = 0;

  seq_match_scheduler #(.NREQ(NREQ), .WIDTH(W), .PATTERN(PAT)) dut (
    .clk(clk), .rst(rst), .req(req), .data(data), .gnt(gnt), .busy(busy),
    .ser_bit(ser_bit), .match_pulse(match_pulse), .done(done),
    .done_id(done_id), .match_cnt(match_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic bit match_at(input logic [W-1:0] w, input int i);
    if (i < 3) return 1'b0;
    for (int j = 0; j < 4; j++)
      if (w[W-1-(i-3+j)] != PAT[3-j]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int count_matches(input logic [W-1:0] w);
    int n = 0;
    for (int i = 0; i < W; i++) n += int'(match_at(w, i));
    return n;
  endfunction

  // Model: decides grants from req at each edge; outputs derive from the grant time.
  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_active = 1'b0; m_last = NREQ - 1; m_done_id = 0; m_done_cnt = 0;
      end else begin
        cyc++;
        if (m_active && cyc == m_t0 + W) begin
          m_done_id  = m_id;
          m_done_cnt = count_matches(m_word);
        end
        if (!m_active || cyc >= m_t0 + W + 2) begin
          m_active = 1'b0;
          for (int k = 1; k <= NREQ; k++) begin
            int c;
            c = (m_last + k) % NREQ;
            if (req[c]) begin
              m_active = 1'b1; m_t0 = cyc; m_id = c; m_last = c;
              m_word = data[c*W +: W];
              break;
            end
          end
        end
      end
    end
  end

  // Compare process: every cycle, mid-cycle.
  int kk, e_gnt, e_busy, e_ser, e_mp, e_done;
  initial begin
    forever begin
      @(negedge clk);
      kk     = cyc - m_t0;
      e_gnt  = (m_active && kk == 0) ? (1 << m_id) : 0;
      e_busy = (m_active && kk >= 0 && kk <= W) ? 1 : 0;
      e_ser  = (m_active && kk >= 0 && kk < W) ? int'(m_word[W-1-kk]) : 0;
      e_mp   = (m_active && kk >= 1 && kk <= W) ? int'(match_at(m_word, kk - 1)) : 0;
      e_done = (m_active && kk == W) ? 1 : 0;
      chk("gnt", int'(gnt), e_gnt);
      chk("busy", int'(busy), e_busy);
      chk("ser_bit", int'(ser_bit), e_ser);
      chk("match_pulse", int'(match_pulse), e_mp);
      chk("done", int'(done), e_done);
      chk("done_id", int'(done_id), m_done_id);
      chk("match_cnt", int'(match_cnt), m_done_cnt);
    end
  end

  // Transaction log: one line per completed word.
  initial begin
    forever begin
      @(negedge clk);
      if (gnt != '0) begin
        for (int c = 0; c < NREQ; c++) if (gnt[c]) gq.push_back(c);
        gcyc.push_back(cyc);
      end
      if (done) begin
        dq.push_back(int'(done_id));
        done_total++;
        $display("txn: ch=%0d match_cnt=%0d cycle=%0d", done_id, match_cnt, cyc);
      end
    end
  end

  task automatic wait_gnt(output int id);
    id = -1;
    for (int n = 0; n < 40 && id < 0; n++) begin
      @(negedge clk);
      for (int c = 0; c < NREQ; c++) if (gnt[c]) id = c;
    end
    if (id < 0) chk("grant_timeout", id, 0);
  endtask

  task automatic wait_done(output int id, output int cnt, output int dc, output int np);
    id = -1; cnt = -1; dc = 0; np = 0;
    for (int n = 0; n < 40 && id < 0; n++) begin
      @(negedge clk);
      np += int'(match_pulse);
      if (done) begin id = int'(done_id); cnt = int'(match_cnt); dc = cyc; end
    end
    if (id < 0) chk("done_timeout", id, 0);
  endtask

  task automatic run_single(input int ch, input logic [W-1:0] word, input int exp_cnt);
    int g, id, cnt, dc, np, gc;
    data[ch*W +: W] = word;
    req[ch] = 1'b1;
    wait_gnt(g);
    gc = cyc;
    req[ch] = 1'b0;
    wait_done(id, cnt, dc, np);
    chk("grant_ch", g, ch);
    chk("result_id", id, ch);
    chk("result_cnt", cnt, exp_cnt);
    chk("pulse_count", np, exp_cnt);
    chk("gnt_to_done", dc - gc, W);
  endtask

  task automatic run_burst(input logic [NREQ-1:0] r, input bit drop);
    int nd, ng;
    nd = 0; ng = 0;
    req = r;
    for (int n = 0; n < 100 && nd < 4; n++) begin
      @(negedge clk);
      if (gnt != '0) begin
        ng++;
        if (drop) req = req & ~gnt;
        else if (ng == 4) req = '0;
      end
      if (done) nd++;
    end
    req = '0;
    chk("burst_done_count", nd, 4);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_gnt"}, int'(gnt), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_ser"}, int'(ser_bit), 0);
    chk({tag, "_mp"}, int'(match_pulse), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_id"}, int'(done_id), 0);
    chk({tag, "_cnt"}, int'(match_cnt), 0);
  endtask

  task automatic do_reset();
    @(negedge clk); #1 rst = 1'b1;
    @(negedge clk); #1 rst = 1'b0;
  endtask

  initial begin
    int g, b, bd, d0, id, cnt, dc, np;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk_zero("reset");
    #1 rst = 1'b0;

    run_single(0, 8'b1011_1011, 2);
    run_single(1, 8'b1011_0110, 2);

    // All four requesting from reset, each dropped once granted.
    do_reset();
    data = {8'h5A, 8'hB6, 8'h2D, 8'hBB};
    b = gq.size(); bd = dq.size();
    run_burst(4'b1111, 1'b1);
    #1;
    chk("burst4_grants", gq.size() - b, 4);
    chk("burst4_dones", dq.size() - bd, 4);
    if (gq.size() - b >= 4 && dq.size() - bd >= 4)
      for (int i = 0; i < 4; i++) begin
        chk("burst4_order", gq[b+i], i);
        chk("burst4_done_id", dq[bd+i], i);
        if (i > 0) chk("burst4_spacing", gcyc[b+i] - gcyc[b+i-1], W + 2);
      end

    // ch0 and ch2 held continuously.
    b = gq.size();
    run_burst(4'b0101, 1'b0);
    #1;
    chk("pair_grants", gq.size() - b, 4);
    if (gq.size() - b >= 4) begin
      chk("pair_order0", gq[b], 0);
      chk("pair_order1", gq[b+1], 2);
      chk("pair_order2", gq[b+2], 0);
      chk("pair_order3", gq[b+3], 2);
    end

    run_single(0, 8'b0000_0101, 0);
    run_single(1, 8'b1000_0000, 0);
    run_single(2, 8'hFF, 0);
    run_single(3, 8'h00, 0);

    // Reset while bit index 4 is on the detector.
    data[0 +: W] = 8'hBB;
    req[0] = 1'b1;
    wait_gnt(g);
    req[0] = 1'b0;
    chk("pre_reset_grant", g, 0);
    repeat (4) @(negedge clk);
    chk("ser_bit_idx4", int'(ser_bit), 1);
    #1 rst = 1'b1;
    #1 chk_zero("midshift");
    d0 = done_total;
    @(negedge clk); #1 rst = 1'b0;
    data[0 +: W] = 8'hB0;
    data[3*W +: W] = 8'h0B;
    req = 4'b1001;
    wait_gnt(g);
    chk("no_done_after_reset", done_total - d0, 0);
    chk("rr_restart_grant", g, 0);
    req[0] = 1'b0;
    wait_gnt(g);
    chk("rr_next_grant", g, 3);
    req[3] = 1'b0;
    wait_done(id, cnt, dc, np);
    chk("last_done_id", id, 3);
    chk("last_match_cnt", cnt, 1);
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

endmodule
